// File: rtl/light_if.sv
// Timer-pulse, pedestrian-request and lamp/status bundle for the light sequencer.
// The bench drives through master; the sequencer owns slave.
interface light_if;
    logic       time1;
    logic       time2;
    logic       ped_req;
    logic [2:0] state;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic       fault;

    modport master (
        output time1, time2, ped_req,
        input  state, ns_light, ew_light, walk, fault
    );

    modport slave (
        input  time1, time2, ped_req,
        output state, ns_light, ew_light, walk, fault
    );
endinterface

// File: rtl/light_sequencer.sv
// Two-way traffic light sequencer with a pedestrian all-red phase, a watchdog
// that traps into a flashing-yellow fault state, and input-independent lamp decode.
module light_sequencer #(
    parameter int WALK_TIME = 10,
    parameter int WATCHDOG  = 40
) (
    input  logic    clk_1hz,
    input  logic    rst,
    light_if.slave  bus
);

    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;
    localparam logic [2:0] S7 = 3'd7;

    localparam int WD_W = $clog2(WATCHDOG + 1);
    localparam int WK_W = $clog2(WALK_TIME + 1);

    logic [2:0]      state_q;
    logic [2:0]      state_d;
    logic [2:0]      ret_q;
    logic            ped_q;
    logic            flash_q;
    logic [WD_W-1:0] wd_cnt;
    logic [WK_W-1:0] walk_cnt;

    logic wd_exp;
    logic walk_done;
    logic enter_s4;
    logic changing;

    assign wd_exp    = (wd_cnt == WD_W'(WATCHDOG - 1));
    assign walk_done = (walk_cnt == WK_W'(WALK_TIME - 1));

    // Only the pulse relevant to the current phase is examined, so stray or
    // simultaneous pulses fall through to the watchdog check.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S0: begin
                if (bus.time1)   state_d = S1;
                else if (wd_exp) state_d = S7;
            end
            S1: begin
                if (bus.time2)   state_d = ped_q ? S4 : S2;
                else if (wd_exp) state_d = S7;
            end
            S2: begin
                if (bus.time1)   state_d = S3;
                else if (wd_exp) state_d = S7;
            end
            S3: begin
                if (bus.time2)   state_d = ped_q ? S4 : S0;
                else if (wd_exp) state_d = S7;
            end
            S4: begin
                if (walk_done)   state_d = ret_q;
            end
            S7:      state_d = S7;
            default: state_d = S7;
        endcase
    end

    assign enter_s4 = (state_d == S4) && (state_q != S4);
    assign changing = (state_d != state_q);

    always_ff @(posedge clk_1hz or posedge rst) begin
        if (rst) begin
            state_q  <= S0;
            ret_q    <= S2;
            ped_q    <= 1'b0;
            flash_q  <= 1'b0;
            wd_cnt   <= '0;
            walk_cnt <= '0;
        end else begin
            state_q <= state_d;

            // A request arriving on the entry edge survives the clear.
            ped_q <= bus.ped_req | (ped_q & ~enter_s4);

            if (enter_s4)
                ret_q <= (state_q == S1) ? S2 : S0;

            if (enter_s4)
                walk_cnt <= '0;
            else if (state_q == S4 && !walk_done)
                walk_cnt <= walk_cnt + 1'b1;

            if (changing)
                wd_cnt <= '0;
            else if (state_q <= S3)
                wd_cnt <= wd_cnt + 1'b1;

            if (state_d == S7)
                flash_q <= (state_q == S7) ? ~flash_q : 1'b1;
            else
                flash_q <= 1'b0;
        end
    end

    // Lamps are {red, yellow, green}, decoded purely from registered state.
    always_comb begin
        bus.state    = state_q;
        bus.ns_light = 3'b100;
        bus.ew_light = 3'b100;
        bus.walk     = 1'b0;
        bus.fault    = 1'b0;
        case (state_q)
            S0: begin
                bus.ns_light = 3'b001;
                bus.ew_light = 3'b100;
            end
            S1: begin
                bus.ns_light = 3'b010;
                bus.ew_light = 3'b100;
            end
            S2: begin
                bus.ns_light = 3'b100;
                bus.ew_light = 3'b001;
            end
            S3: begin
                bus.ns_light = 3'b100;
                bus.ew_light = 3'b010;
            end
            S4: begin
                bus.walk = 1'b1;
            end
            S7: begin
                bus.ns_light = {1'b0, flash_q, 1'b0};
                bus.ew_light = {1'b0, flash_q, 1'b0};
                bus.fault    = 1'b1;
            end
            default: begin
                bus.ns_light = 3'b100;
                bus.ew_light = 3'b100;
            end
        endcase
    end

endmodule

// File: tb/tb_light_sequencer.sv
// Directed scenario bench for light_sequencer; inputs change and outputs are
// sampled on the falling edge of clk_1hz.
module tb_light_sequencer;

    logic clk_1hz = 1'b0;
    logic rst     = 1'b0;
    int   total   = 0;
    int   passed  = 0;

    light_if bus ();

    light_sequencer #(.WALK_TIME(10), .WATCHDOG(40)) dut (
        .clk_1hz (clk_1hz),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk_1hz = ~clk_1hz;

    initial begin
        #200000;
        $display("FAIL timeout state=%0d expected=finished", bus.state);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk_1hz);
        @(negedge clk_1hz);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input logic t1, input logic t2, input logic pr);
        bus.time1 = t1; bus.time2 = t2; bus.ped_req = pr;
        tick();
        bus.time1 = 1'b0; bus.time2 = 1'b0; bus.ped_req = 1'b0;
    endtask

    task automatic do_reset();
        bus.time1 = 1'b0; bus.time2 = 1'b0; bus.ped_req = 1'b0;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.time1 = 1'b0; bus.time2 = 1'b0; bus.ped_req = 1'b0;
        @(negedge clk_1hz);
        #2 rst = 1'b1;
        #1;
        total++; if (bus.state !== 3'd0) $display("FAIL rst_state got=%0d exp=0", bus.state); else passed++;
        total++; if (bus.ns_light !== 3'b001) $display("FAIL rst_ns got=%b exp=001", bus.ns_light); else passed++;
        total++; if (bus.ew_light !== 3'b100) $display("FAIL rst_ew got=%b exp=100", bus.ew_light); else passed++;
        total++; if ({bus.walk, bus.fault} !== 2'b00) $display("FAIL rst_walk_fault got=%b exp=00", {bus.walk, bus.fault}); else passed++;
        @(negedge clk_1hz);
        rst = 1'b0;
    endtask

    task automatic test_normal();
        do_reset();
        idle(29);
        pulse(1, 0, 0);
        total++; if ({bus.state, bus.ns_light, bus.ew_light} !== {3'd1, 3'b010, 3'b100})
            $display("FAIL norm_s1 got=%0d/%b/%b exp=1/010/100", bus.state, bus.ns_light, bus.ew_light); else passed++;
        idle(2);
        pulse(0, 1, 0);
        total++; if ({bus.state, bus.ns_light, bus.ew_light} !== {3'd2, 3'b100, 3'b001})
            $display("FAIL norm_s2 got=%0d/%b/%b exp=2/100/001", bus.state, bus.ns_light, bus.ew_light); else passed++;
        idle(29);
        pulse(1, 0, 0);
        total++; if ({bus.state, bus.ns_light, bus.ew_light} !== {3'd3, 3'b100, 3'b010})
            $display("FAIL norm_s3 got=%0d/%b/%b exp=3/100/010", bus.state, bus.ns_light, bus.ew_light); else passed++;
        idle(2);
        pulse(0, 1, 0);
        total++; if ({bus.state, bus.ns_light, bus.ew_light, bus.walk} !== {3'd0, 3'b001, 3'b100, 1'b0})
            $display("FAIL norm_s0 got=%0d/%b/%b/%b exp=0/001/100/0", bus.state, bus.ns_light, bus.ew_light, bus.walk); else passed++;
    endtask

    task automatic test_stray();
        do_reset();
        pulse(0, 1, 0);
        total++; if (bus.state !== 3'd0) $display("FAIL stray_t2_s0 got=%0d exp=0", bus.state); else passed++;
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        total++; if (bus.state !== 3'd1) $display("FAIL stray_t1_s1 got=%0d exp=1", bus.state); else passed++;
        pulse(0, 1, 0);
        pulse(1, 1, 0);
        total++; if (bus.state !== 3'd3) $display("FAIL stray_both_s2 got=%0d exp=3", bus.state); else passed++;
        pulse(1, 1, 0);
        total++; if (bus.state !== 3'd0) $display("FAIL stray_both_s3 got=%0d exp=0", bus.state); else passed++;
    endtask

    task automatic test_ped();
        int cnt;
        do_reset();
        pulse(0, 0, 1);
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        total++; if ({bus.state, bus.walk, bus.ns_light, bus.ew_light} !== {3'd4, 1'b1, 3'b100, 3'b100})
            $display("FAIL ped_entry got=%0d/%b/%b/%b exp=4/1/100/100", bus.state, bus.walk, bus.ns_light, bus.ew_light); else passed++;
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.state != 3'd4) break;
            cnt++;
        end
        total++; if (cnt !== 10) $display("FAIL ped_walk_len got=%0d exp=10", cnt); else passed++;
        total++; if ({bus.state, bus.walk} !== {3'd2, 1'b0}) $display("FAIL ped_return got=%0d/%b exp=2/0", bus.state, bus.walk); else passed++;
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        total++; if (bus.state !== 3'd0) $display("FAIL ped_latch_clear got=%0d exp=0", bus.state); else passed++;
    endtask

    task automatic test_walk_req();
        do_reset();
        pulse(0, 0, 1);
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        idle(2);
        pulse(0, 0, 1);
        for (int i = 0; i < 20 && bus.state == 3'd4; i++) tick();
        total++; if (bus.state !== 3'd2) $display("FAIL wreq_return got=%0d exp=2", bus.state); else passed++;
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        total++; if ({bus.state, bus.walk} !== {3'd4, 1'b1}) $display("FAIL wreq_reenter got=%0d/%b exp=4/1", bus.state, bus.walk); else passed++;
    endtask

    task automatic test_ped_on_entry();
        do_reset();
        pulse(1, 0, 1);
        pulse(0, 1, 1);
        total++; if (bus.state !== 3'd4) $display("FAIL pentry_s4 got=%0d exp=4", bus.state); else passed++;
        for (int i = 0; i < 20 && bus.state == 3'd4; i++) tick();
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        total++; if (bus.state !== 3'd4) $display("FAIL pentry_served got=%0d exp=4", bus.state); else passed++;
    endtask

    task automatic test_watchdog();
        do_reset();
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        idle(39);
        total++; if (bus.state !== 3'd2) $display("FAIL wd_edge39 got=%0d exp=2", bus.state); else passed++;
        tick();
        total++; if ({bus.state, bus.fault, bus.walk, bus.ns_light, bus.ew_light} !== {3'd7, 1'b1, 1'b0, 3'b010, 3'b010})
            $display("FAIL wd_fault got=%0d/%b/%b/%b/%b exp=7/1/0/010/010", bus.state, bus.fault, bus.walk, bus.ns_light, bus.ew_light); else passed++;
        tick();
        total++; if ({bus.ns_light, bus.ew_light} !== {3'b000, 3'b000})
            $display("FAIL wd_flash0 got=%b/%b exp=000/000", bus.ns_light, bus.ew_light); else passed++;
        tick();
        total++; if ({bus.ns_light, bus.ew_light} !== {3'b010, 3'b010})
            $display("FAIL wd_flash1 got=%b/%b exp=010/010", bus.ns_light, bus.ew_light); else passed++;
        pulse(1, 1, 1);
        total++; if ({bus.state, bus.fault, bus.ns_light} !== {3'd7, 1'b1, 3'b000})
            $display("FAIL wd_terminal got=%0d/%b/%b exp=7/1/000", bus.state, bus.fault, bus.ns_light); else passed++;
        rst = 1'b1;
        #1;
        total++; if ({bus.state, bus.fault, bus.ns_light, bus.ew_light} !== {3'd0, 1'b0, 3'b001, 3'b100})
            $display("FAIL wd_rst got=%0d/%b/%b/%b exp=0/0/001/100", bus.state, bus.fault, bus.ns_light, bus.ew_light); else passed++;
        @(negedge clk_1hz);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_walk();
        do_reset();
        pulse(0, 0, 1);
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        idle(4);
        rst = 1'b1;
        #1;
        total++; if ({bus.state, bus.walk, bus.fault, bus.ns_light, bus.ew_light} !== {3'd0, 1'b0, 1'b0, 3'b001, 3'b100})
            $display("FAIL mrst_out got=%0d/%b/%b/%b/%b exp=0/0/0/001/100", bus.state, bus.walk, bus.fault, bus.ns_light, bus.ew_light); else passed++;
        @(negedge clk_1hz);
        rst = 1'b0;
        pulse(1, 0, 0);
        total++; if (bus.state !== 3'd1) $display("FAIL mrst_first_edge got=%0d exp=1", bus.state); else passed++;
    endtask

    initial begin
        bus.time1 = 1'b0; bus.time2 = 1'b0; bus.ped_req = 1'b0;
        test_reset();
        test_normal();
        test_stray();
        test_ped();
        test_walk_req();
        test_ped_on_entry();
        test_watchdog();
        test_reset_mid_walk();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/light_sequencer.md
LIGHT_SEQUENCER -- requirements
Module: light_sequencer

Interface
REQ-001 Parameter: WALK_TIME, 10, clk_1hz cycles spent in the all-red pedestrian phase S4.
REQ-002 Parameter: WATCHDOG, 40, clk_1hz cycles allowed in any of S0-S3 without the expected expiry pulse.
REQ-003 clk_1hz  input  1  system clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 time1  input  1  green-expiry pulse; one cycle wide.
REQ-006 time2  input  1  yellow-expiry pulse; one cycle wide.
REQ-007 ped_req  input  1  pedestrian request; any cycle sampled high registers a request.
REQ-008 state  output  3  current phase code; fed back to the phase timer.
REQ-009 ns_light  output  3  north-south lamps, {red, yellow, green}, one-hot except in fault.
REQ-010 ew_light  output  3  east-west lamps, {red, yellow, green}, one-hot except in fault.
REQ-011 walk  output  1  pedestrian walk lamp.
REQ-012 fault  output  1  watchdog fault indicator.

Function
REQ-013 The state codes SHALL be: S0=3'd0 NS green/EW red; S1=3'd1 NS yellow/EW red; S2=3'd2 NS red/EW green; S3=3'd3 NS red/EW yellow; S4=3'd4 all red, walk on; S7=3'd7 fault. Codes 5 and 6 SHALL go to S7 on the next edge.
REQ-014 State SHALL be registered. Each transition SHALL take effect on the same edge that samples the triggering pulse high.
REQ-015 In S0, time1=1 SHALL move to S1. In S2, time1=1 SHALL move to S3.
REQ-016 In S1, time2=1 SHALL move to S4 if a pedestrian request is pending; otherwise it SHALL move to S2.
REQ-017 In S3, time2=1 SHALL move to S4 if a pedestrian request is pending; otherwise it SHALL move to S0.
REQ-018 On entry to S4, a return register SHALL record the next green phase: S2 when entering from S1, S0 when entering from S3.
REQ-019 On entry to S4, a walk counter SHALL clear to 0. After WALK_TIME cycles in S4, the FSM SHALL move to the recorded green phase.
REQ-020 A pulse not expected in the current state SHALL be ignored: time2 in S0/S2, time1 in S1/S3, either pulse in S4/S7.
REQ-021 If time1 and time2 are high together, only the pulse relevant to the current state SHALL act.
REQ-022 The pedestrian latch SHALL set on ped_req=1 and clear on the edge that enters S4.
REQ-023 ped_req=1 on the edge that enters S4 SHALL leave the latch set, to be served on the next cycle.
REQ-024 ped_req=1 during S4 SHALL set the latch for the following cycle.
REQ-025 The watchdog counter SHALL clear on every state change and SHALL increment by 1 per cycle in S0-S3. It SHALL be wide enough for WATCHDOG with no wrap.
REQ-026 When the watchdog counter reaches WATCHDOG-1 and no valid transition occurs on that edge, the FSM SHALL enter S7.
REQ-027 S7 SHALL be terminal until rst. In S7: fault=1, walk=0, both red lamps 0, both yellow lamps driven from a flash bit that toggles every cycle, starting at 1 on entry.
REQ-028 Lamp outputs SHALL decode from the state register and flash bit only, with no dependence on inputs in the same cycle. walk SHALL be 1 only in S4.

Reset
REQ-029 rst=1 SHALL immediately force: state=S0, ns_light=3'b001, ew_light=3'b100, walk=0, fault=0, pedestrian latch=0, watchdog=0, walk counter=0, flash bit=0, return register=S2.
REQ-030 rst asserted mid-phase, including in S4 or S7, SHALL abandon the phase; after release, sequencing SHALL restart from S0.
REQ-031 The first edge after rst deasserts SHALL evaluate inputs normally.

Verification
REQ-032 Normal cycle: pulse time1 at cycle 30, time2 at 33, time1 at 63, time2 at 66 -> state sequence 0,1,2,3,0 with matching one-hot lamps; walk stays 0.
REQ-033 Pedestrian: ped_req pulse during S0, then time1 then time2 -> S4 for exactly 10 cycles with walk=1 and both lamps 3'b100, then S2; latch clear after entry.
REQ-034 Stray pulses: time2 in S0 and time1 in S1 -> no state change; simultaneous time1 and time2 in S3 -> S0.
REQ-035 Watchdog: hold S2 with no time1 for 40 cycles -> S7 on the 40th edge, fault=1, yellows alternate 1,0,1...; later pulses -> remain S7.
REQ-036 Reset mid-walk: assert rst at cycle 5 of S4 -> outputs at reset values immediately; after release, time1 moves to S1.
REQ-037 Request during walk: ped_req high while in S4 -> after the return to green and the next yellow, the FSM enters S4 again.
